// File: rtl/pll_reset_sequencer_pkg.sv
// Shared constants for the PLL reset sequencer.
// State encodings and default parameter values.
package pll_reset_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_RESET_HOLD_CYCLES  = 64;
    localparam int unsigned DEF_SYNC_STAGES        = 2;
    localparam int unsigned DEF_LOSS_CNT_W         = 8;

    // Counter width for a terminal count of n cycles.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input.
// Chain resets to RESET_VAL so the output starts inactive.
module sync_bit
    import pll_reset_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock qualification, reset stretch and system reset generation.
// Runs on the PLL output clock; counts lock losses seen in RUN.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int unsigned LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  locked,
    input  logic                  button_n,
    output logic                  sys_reset_n,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int unsigned SW = cnt_w(LOCK_STABLE_CYCLES);
    localparam int unsigned HW = cnt_w(RESET_HOLD_CYCLES);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD_CYCLES - 1);

    logic          lock_s;
    logic          btn_s;
    logic [SW-1:0] stable_cnt;
    logic [HW-1:0] hold_cnt;

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked),
        .q       (lock_s)
    );

    sync_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_btn_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (button_n),
        .q       (btn_s)
    );

    // Sequencer FSM with qualification, hold and loss counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_LOCK;
            stable_cnt      <= '0;
            hold_cnt        <= '0;
            lock_loss_count <= '0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    stable_cnt <= '0;
                    if (lock_s) state <= STABLE;
                end
                STABLE: begin
                    if (!lock_s) begin
                        state      <= WAIT_LOCK;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= HOLD;
                        stable_cnt <= '0;
                        hold_cnt   <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (!btn_s) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state <= RUN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        if (lock_loss_count != '1)
                            lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
                    end else if (!btn_s) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // Registered reset/ready outputs; assert at once on reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
        end else begin
            sys_reset_n <= (state == RUN);
            ready       <= (state == RUN);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Small parameters: 8-cycle lock window, 4-cycle hold.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       locked;
    logic       button_n;
    logic       sys_reset_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;

    int pass_cnt = 0;
    int fail_cnt = 0;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .SYNC_STAGES        (2),
        .LOSS_CNT_W         (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .locked          (locked),
        .button_n        (button_n),
        .sys_reset_n     (sys_reset_n),
        .ready           (ready),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clock = ~clock;

    // Advance n rising edges, then settle 1 time unit.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        locked   = 1'b1;
        button_n = 1'b1;

        // Power-on reset held 3 cycles with lock present.
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("por_srst", 32'(sys_reset_n), 0);
        end
        chk("por_state", 32'(state), 0);
        chk("por_ready", 32'(ready), 0);
        chk("por_cnt", 32'(lock_loss_count), 0);

        // Release: 2 sync + 1 + 8 stable + 4 hold + 1 output = 16.
        reset_n = 1'b1;
        step(3);
        chk("pu_stable", 32'(state), 1);
        step(8);
        chk("pu_hold", 32'(state), 2);
        step(4);
        chk("pu_run", 32'(state), 3);
        chk("pu_srst15", 32'(sys_reset_n), 0);
        step(1);
        chk("pu_srst16", 32'(sys_reset_n), 1);
        chk("pu_ready", 32'(ready), 1);
        chk("pu_cnt", 32'(lock_loss_count), 0);

        // Lock loss in RUN.
        locked = 1'b0;
        step(2);
        chk("loss_run2", 32'(state), 3);
        step(1);
        chk("loss_state", 32'(state), 0);
        chk("loss_cnt", 32'(lock_loss_count), 1);
        step(1);
        chk("loss_srst", 32'(sys_reset_n), 0);
        chk("loss_ready", 32'(ready), 0);

        // Relock, then glitch after 5 cycles in STABLE.
        locked = 1'b1;
        step(3);
        chk("gl_stable", 32'(state), 1);
        step(5);
        locked = 1'b0;
        step(3);
        chk("gl_back", 32'(state), 0);
        locked = 1'b1;
        step(3);
        chk("gl_restab", 32'(state), 1);
        step(7);
        chk("gl_full8", 32'(state), 1);
        step(1);
        chk("gl_hold", 32'(state), 2);
        step(5);
        chk("gl_srst", 32'(sys_reset_n), 1);
        chk("gl_cnt", 32'(lock_loss_count), 1);

        // Button held 6 cycles in RUN.
        button_n = 1'b0;
        step(3);
        chk("btn_hold", 32'(state), 2);
        step(1);
        chk("btn_srst", 32'(sys_reset_n), 0);
        step(2);
        button_n = 1'b1;
        step(5);
        chk("btn_still", 32'(state), 2);
        step(1);
        chk("btn_run", 32'(state), 3);
        chk("btn_srst12", 32'(sys_reset_n), 0);
        step(1);
        chk("btn_srst13", 32'(sys_reset_n), 1);
        chk("btn_cnt", 32'(lock_loss_count), 1);

        // Lock loss and button together: loss wins.
        locked   = 1'b0;
        button_n = 1'b0;
        step(3);
        chk("sim_state", 32'(state), 0);
        chk("sim_cnt", 32'(lock_loss_count), 2);
        step(1);
        chk("sim_srst", 32'(sys_reset_n), 0);
        button_n = 1'b1;
        locked   = 1'b1;
        step(16);
        chk("sim_relock", 32'(sys_reset_n), 1);

        // 300 loss/relock rounds; counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            step(4);
            locked = 1'b1;
            step(16);
            if (i == 99)
                chk("sat_mid", 32'(lock_loss_count), 102);
        end
        chk("sat_cnt", 32'(lock_loss_count), 255);
        chk("sat_run", 32'(sys_reset_n), 1);

        // Async reset in RUN, no clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_run_srst", 32'(sys_reset_n), 0);
        chk("ar_run_state", 32'(state), 0);
        chk("ar_run_cnt", 32'(lock_loss_count), 0);
        step(1);
        reset_n = 1'b1;
        step(12);
        chk("ar_hold_pre", 32'(state), 2);

        // Async reset in HOLD, no clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_hold_srst", 32'(sys_reset_n), 0);
        chk("ar_hold_state", 32'(state), 0);
        chk("ar_hold_ready", 32'(ready), 0);
        chk("ar_hold_cnt", 32'(lock_loss_count), 0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
